// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared width default and per-bit operation decode for the toggle flip-flop
package t_ff_pkg;
  localparam int T_FF_DEFAULT_WIDTH = 1;
  typedef enum logic {HOLD, TOGGLE} t_ff_op_e;
endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: one toggle bit with sync reset; T_FF_PRESET_EN adds a sync preset below reset
module t_ff_cell import t_ff_pkg::*; #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
`ifdef T_FF_PRESET_EN
  input  logic preset,
`endif
  input  logic t,
  output logic q
);
  t_ff_op_e op;
  logic set;
  assign op = t ? TOGGLE : HOLD;
`ifdef T_FF_PRESET_EN
  assign set = preset;
`else
  assign set = 1'b0;
`endif
  always_ff @(posedge clk)
    q <= reset ? RST_VAL : set ? 1'b1 : (op == TOGGLE) ? ~q : q;
endmodule

// File: rtl/t_flip_flop.sv
// t_flip_flop: WIDTH independent toggle cells with Q_bar = ~Q; macro T_FF_PRESET_EN adds a preset input
module t_flip_flop import t_ff_pkg::*; #(
  parameter int               WIDTH     = T_FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  input  logic [WIDTH-1:0] T,
  input  logic             clk,
  input  logic             reset
`ifdef T_FF_PRESET_EN
  ,
  input  logic             preset
`endif
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
      .clk   (clk),
      .reset (reset),
`ifdef T_FF_PRESET_EN
      .preset(preset),
`endif
      .t     (T[i]),
      .q     (Q[i])
    );
  end
  assign Q_bar = ~Q;
endmodule

// File: tb/tb_t_flip_flop.sv
// tb_t_flip_flop: scoreboard bench, directed then random stimulus against an XOR-accumulator model
module tb_t_flip_flop;
  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b1010;
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] T;
  logic [W-1:0] Q, Q_bar;
`ifdef T_FF_PRESET_EN
  logic         preset;
`endif
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;
  int cmps = 0;
  int errs = 0;
  bit done = 1'b0;

  t_flip_flop #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .Q     (Q),
    .Q_bar (Q_bar),
    .T     (T),
    .clk   (clk),
    .reset (reset)
`ifdef T_FF_PRESET_EN
    ,
    .preset(preset)
`endif
  );

  always #10 clk = ~clk;

  // Q after an edge is the reset value, all ones on preset, or Q xor T
  task automatic step(input logic r, input logic p, input logic [W-1:0] t);
    reset = r;
    T = t;
`ifdef T_FF_PRESET_EN
    preset = p;
    model = r ? RV : p ? '1 : model ^ t;
`else
    model = r ? RV : model ^ t;
`endif
    exp_q.push_back(model);
    @(posedge clk);
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmps++;
        if (Q !== e) begin
          errs++;
          $display("FAIL q t=%0t got %b want %b", $time, Q, e);
        end
        cmps++;
        if (Q_bar !== ~e) begin
          errs++;
          $display("FAIL q_bar t=%0t got %b want %b", $time, Q_bar, ~e);
        end
      end
    end
  end

  initial begin : driver
    model = '0;
    step(1'b1, 1'b0, '0);
    #2;
    step(1'b0, 1'b0, '0);
    @(negedge clk) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) @(negedge clk) step(1'b0, 1'b0, '1);
    for (int i = 0; i < 16; i++) @(negedge clk) step(1'b0, 1'b0, {W{i[0]}});
    @(negedge clk) step(1'b0, 1'b0, 4'b0001);
    @(negedge clk) step(1'b1, 1'b0, '1);
    @(negedge clk) step(1'b0, 1'b0, 4'b0011);
`ifdef T_FF_PRESET_EN
    @(negedge clk) step(1'b0, 1'b1, '1);
    @(negedge clk) step(1'b1, 1'b1, '1);
`endif
    for (int i = 0; i < 60; i++)
      @(negedge clk) step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, W'($urandom));
    done = 1'b1;
  end

  initial begin : finisher
    wait (done);
    repeat (3) @(posedge clk);
    #2;
    cmps++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
